// File: rtl/register_file.sv
// 32 x 32-bit general-purpose register file for the single-cycle datapath.
// Two combinational read ports, one synchronous write port, r0 hardwired to zero.
module register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] a1,
    input  logic [ADDR_W-1:0] a2,
    input  logic [ADDR_W-1:0] a3,
    input  logic [DATA_W-1:0] wd,
    input  logic              rfwr,
    output logic [DATA_W-1:0] rd1,
    output logic [DATA_W-1:0] rd2
);

    localparam int DEPTH = 1 << ADDR_W;

    // r0 has no storage; index range starts at 1 so it cannot be written by accident
    logic [DATA_W-1:0] regs [1:DEPTH-1];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (rfwr && (a3 != '0)) begin
            regs[a3] <= wd;
        end
    end

    // No write-to-read bypass: a same-cycle read sees the pre-edge contents
    always_comb begin
        rd1 = '0;
        rd2 = '0;
        if (a1 != '0) begin
            rd1 = regs[a1];
        end
        if (a2 != '0) begin
            rd2 = regs[a2];
        end
    end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: directed scenarios plus randomized traffic
// compared against an array-based reference model of the register contents.
module tb_register_file;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int DEPTH  = 1 << ADDR_W;

    logic              clk;
    logic              rst;
    logic [ADDR_W-1:0] a1;
    logic [ADDR_W-1:0] a2;
    logic [ADDR_W-1:0] a3;
    logic [DATA_W-1:0] wd;
    logic              rfwr;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;

    logic [DATA_W-1:0] model [DEPTH];
    int checks;
    int errors;

    register_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk (clk),
        .rst (rst),
        .a1  (a1),
        .a2  (a2),
        .a3  (a3),
        .wd  (wd),
        .rfwr(rfwr),
        .rd1 (rd1),
        .rd2 (rd2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DATA_W-1:0] expect_rd(input logic [ADDR_W-1:0] a);
        return (a == 0) ? '0 : model[a];
    endfunction

    // Advance one rising edge, updating the model from the inputs sampled there
    task automatic tick();
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) model[i] = '0;
        end else if (rfwr && a3 != 0) begin
            model[a3] = wd;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rfwr = 1'b0; a3 = '0; wd = '0;
        tick();
        rst = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a1 = ADDR_W'(i); a2 = ADDR_W'(DEPTH - 1 - i);
            #1;
            checks++;
            if (rd1 !== '0 || rd2 !== '0) begin
                errors++;
                $display("[TB] FAIL reset_clear a1=%0d rd1=%h rd2=%h required 0/0", i, rd1, rd2);
            end
        end
    endtask

    task automatic test_fill();
        for (int i = 1; i <= 9; i++) begin
            rfwr = 1'b1; a3 = ADDR_W'(i); wd = DATA_W'(i);
            tick();
        end
        rfwr = 1'b0;
        for (int i = 0; i <= 8; i += 2) begin
            a1 = ADDR_W'(i); a2 = ADDR_W'(i + 1);
            #1;
            checks++;
            if (rd1 !== DATA_W'(i) || rd2 !== DATA_W'(i + 1)) begin
                errors++;
                $display("[TB] FAIL fill_pair (%0d,%0d) got %h/%h required %0d/%0d",
                         i, i + 1, rd1, rd2, i, i + 1);
            end
        end
    endtask

    task automatic test_r0();
        rfwr = 1'b1; a3 = '0; wd = 32'hDEADBEEF;
        tick();
        rfwr = 1'b0;
        a1 = '0; a2 = '0;
        #1;
        checks++;
        if (rd1 !== '0 || rd2 !== '0) begin
            errors++;
            $display("[TB] FAIL r0_hardwire got %h/%h required 0/0", rd1, rd2);
        end
    endtask

    task automatic test_write_enable();
        a1 = 5'd5;
        rfwr = 1'b0; a3 = 5'd5; wd = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (rd1 !== 32'd5) begin
                errors++;
                $display("[TB] FAIL write_enable edge %0d rd1=%h required 5", i, rd1);
            end
        end
    endtask

    task automatic test_same_address();
        a1 = 5'd7;
        rfwr = 1'b1; a3 = 5'd7; wd = 32'h12345678;
        #1;
        checks++;
        if (rd1 !== 32'd7) begin
            errors++;
            $display("[TB] FAIL same_addr_pre rd1=%h required 7", rd1);
        end
        tick();
        rfwr = 1'b0;
        checks++;
        if (rd1 !== 32'h12345678) begin
            errors++;
            $display("[TB] FAIL same_addr_post rd1=%h required 12345678", rd1);
        end
    endtask

    task automatic test_reset_priority();
        rst = 1'b1; rfwr = 1'b1; a3 = 5'd3; wd = 32'd99;
        tick();
        rst = 1'b0; rfwr = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            a1 = ADDR_W'(i); a2 = ADDR_W'(i);
            #1;
            checks++;
            if (rd1 !== '0 || rd2 !== '0) begin
                errors++;
                $display("[TB] FAIL reset_priority addr=%0d got %h/%h required 0/0", i, rd1, rd2);
            end
        end
    endtask

    task automatic test_boundary();
        rfwr = 1'b1;
        a3 = 5'd29; wd = 32'h29292929; tick();
        a3 = 5'd31; wd = 32'hFFFFFFFF; tick();
        a3 = 5'd30; wd = 32'h80000001; tick();
        rfwr = 1'b0;
        a1 = 5'd31; a2 = 5'd30;
        #1;
        checks++;
        if (rd1 !== 32'hFFFFFFFF || rd2 !== 32'h80000001) begin
            errors++;
            $display("[TB] FAIL boundary got %h/%h required ffffffff/80000001", rd1, rd2);
        end
        a1 = 5'd29;
        #1;
        checks++;
        if (rd1 !== 32'h29292929) begin
            errors++;
            $display("[TB] FAIL boundary_r29 rd1=%h required 29292929", rd1);
        end
    endtask

    // Random writes, occasional resets, and reads before and after each edge
    task automatic test_random();
        for (int n = 0; n < 300; n++) begin
            rst  = ($urandom_range(0, 29) == 0);
            rfwr = $urandom_range(0, 1);
            a3   = ADDR_W'($urandom_range(0, DEPTH - 1));
            wd   = $urandom;
            a1   = ($urandom_range(0, 3) == 0) ? a3 : ADDR_W'($urandom_range(0, DEPTH - 1));
            a2   = ADDR_W'($urandom_range(0, DEPTH - 1));
            #1;
            checks++;
            if (rd1 !== expect_rd(a1) || rd2 !== expect_rd(a2)) begin
                errors++;
                $display("[TB] FAIL random_pre n=%0d a1=%0d a2=%0d got %h/%h required %h/%h",
                         n, a1, a2, rd1, rd2, expect_rd(a1), expect_rd(a2));
            end
            tick();
            checks++;
            if (rd1 !== expect_rd(a1) || rd2 !== expect_rd(a2)) begin
                errors++;
                $display("[TB] FAIL random_post n=%0d a1=%0d a2=%0d got %h/%h required %h/%h",
                         n, a1, a2, rd1, rd2, expect_rd(a1), expect_rd(a2));
            end
        end
        rst = 1'b0; rfwr = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1; rfwr = 1'b0; a1 = '0; a2 = '0; a3 = '0; wd = '0;
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge clk);
        test_reset();
        test_fill();
        test_r0();
        test_write_enable();
        test_same_address();
        test_reset_priority();
        test_boundary();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
